reg_ram_1rw: RTL and testbench

- Flop-based single-port synchronous RAM with one shared address for read and write; the read is registered.
- Used as the tag, valid, dirty and 128-bit data arrays of the L2 cache, and by other cache blocks needing a small 1R/W array.
- Depth is 2**LG_DEPTH words of WIDTH bits.

---
 rtl/reg_ram_1rw.sv | 36 +++
 tb/tb_reg_ram_1rw.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/reg_ram_1rw.sv
// rtl/reg_ram_1rw.sv - flop-based single-port RAM, shared address, registered read-first output
module reg_ram_1rw #(
    parameter int WIDTH    = 32,
    parameter int LG_DEPTH = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [LG_DEPTH-1:0] addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                wr_en,
    output logic [WIDTH-1:0]    rd_data
);

    localparam int DEPTH = 1 << LG_DEPTH;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;

    // Read samples mem before this edge's write lands, giving read-first collisions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[addr] <= wr_data;
            end
            rd_q <= mem[addr];
        end
    end

    assign rd_data = rd_q;

endmodule

// File: tb/tb_reg_ram_1rw.sv
// tb/tb_reg_ram_1rw.sv - directed self-checking bench for reg_ram_1rw at three geometries
module tb_reg_ram_1rw;

    logic clk;
    logic reset;

    logic [3:0]   a8;
    logic [7:0]   wd8;
    logic         we8;
    logic [7:0]   rd8;

    logic [8:0]   a1;
    logic [0:0]   wd1;
    logic         we1;
    logic [0:0]   rd1;

    logic [1:0]   a128;
    logic [127:0] wd128;
    logic         we128;
    logic [127:0] rd128;

    int vectors;
    int miscompares;

    reg_ram_1rw #(.WIDTH(8), .LG_DEPTH(4)) u_ram8 (
        .clk(clk), .reset(reset), .addr(a8), .wr_data(wd8), .wr_en(we8), .rd_data(rd8)
    );

    reg_ram_1rw #(.WIDTH(1), .LG_DEPTH(9)) u_ram1 (
        .clk(clk), .reset(reset), .addr(a1), .wr_data(wd1), .wr_en(we1), .rd_data(rd1)
    );

    reg_ram_1rw #(.WIDTH(128), .LG_DEPTH(2)) u_ram128 (
        .clk(clk), .reset(reset), .addr(a128), .wr_data(wd128), .wr_en(we128), .rd_data(rd128)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b0;
        a8 = '0;   wd8 = '0;   we8 = 1'b0;
        a1 = '0;   wd1 = '0;   we1 = 1'b0;
        a128 = '0; wd128 = '0; we128 = 1'b0;

        tick();
        tick();

        // Mid-cycle async reset: output clears without any clock edge.
        #3 reset = 1'b1;
        #1 check_vec("reset_async_rd8", {120'b0, rd8}, 128'h0);
        check_vec("reset_async_rd1", {127'b0, rd1}, 128'h0);
        check_vec("reset_async_rd128", rd128, 128'h0);

        // Writes during reset are ignored.
        tick();
        a8 = 4'd2; wd8 = 8'h55; we8 = 1'b1;
        tick();
        check_vec("reset_hold_rd8", {120'b0, rd8}, 128'h0);
        we8 = 1'b0;
        #2 reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            tick();
            a8 = i[3:0];
            tick();
            check_vec($sformatf("post_reset_zero_%0d", i), {120'b0, rd8}, 128'h0);
        end

        // Write then read.
        a8 = 4'd3; wd8 = 8'hA5; we8 = 1'b1;
        tick();
        we8 = 1'b0;
        tick();
        check_vec("write_read_a5", {120'b0, rd8}, 128'hA5);

        // Read-first collision.
        a8 = 4'd5; wd8 = 8'h11; we8 = 1'b1;
        tick();
        wd8 = 8'h22;
        tick();
        check_vec("collision_old", {120'b0, rd8}, 128'h11);
        we8 = 1'b0;
        tick();
        check_vec("collision_new", {120'b0, rd8}, 128'h22);

        // Back-to-back writes: last wins.
        a8 = 4'd6; wd8 = 8'h33; we8 = 1'b1;
        tick();
        wd8 = 8'h44;
        tick();
        we8 = 1'b0;
        tick();
        check_vec("last_write_wins", {120'b0, rd8}, 128'h44);
        a8 = 4'd3;
        tick();
        check_vec("addr3_retained", {120'b0, rd8}, 128'hA5);

        // 1-bit sweep over all 512 addresses.
        we1 = 1'b1;
        for (int i = 0; i < 512; i++) begin
            a1 = i[8:0];
            wd1 = i[0];
            tick();
        end
        we1 = 1'b0;
        for (int i = 0; i < 512; i++) begin
            a1 = i[8:0];
            tick();
            check_vec($sformatf("sweep1_%0d", i), {127'b0, rd1}, {127'b0, i[0]});
        end

        // Wide word bit-exactness and neighbour isolation.
        a128 = 2'd0; wd128 = 128'h0123456789ABCDEF_FEDCBA9876543210; we128 = 1'b1;
        tick();
        a128 = 2'd1; wd128 = {128{1'b1}};
        tick();
        we128 = 1'b0;
        a128 = 2'd0;
        tick();
        check_vec("wide_addr0", rd128, 128'h0123456789ABCDEF_FEDCBA9876543210);
        a128 = 2'd1;
        tick();
        check_vec("wide_addr1", rd128, {128{1'b1}});
        a128 = 2'd2;
        tick();
        check_vec("wide_addr2", rd128, 128'h0);
        a128 = 2'd3;
        tick();
        check_vec("wide_addr3", rd128, 128'h0);

        // Reset after data written.
        a8 = 4'd7; wd8 = 8'hFF; we8 = 1'b1;
        tick();
        we8 = 1'b0;
        tick();
        check_vec("pre_reset_ff", {120'b0, rd8}, 128'hFF);
        #3 reset = 1'b1;
        #1 check_vec("reset_again_rd8", {120'b0, rd8}, 128'h0);
        check_vec("reset_again_rd128", rd128, 128'h0);
        #1 reset = 1'b0;
        tick();
        check_vec("addr7_cleared", {120'b0, rd8}, 128'h0);
        a1 = 9'd511;
        a128 = 2'd1;
        tick();
        check_vec("sweep1_511_cleared", {127'b0, rd1}, 128'h0);
        check_vec("wide_addr1_cleared", rd128, 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
